// File: rtl/adc_responder_if.sv
// Pin bundle between a serial ADC controller and the emulated dual-channel ADC.
// The controller drives the master side; the responder sits on the slave side.
interface adc_responder_if #(
  parameter int DATA_W = 12
);
  logic              ADC_CNVST;
  logic              ADC_SCLK;
  logic              ADC_CS_N;
  logic [DATA_W-1:0] SAMPLE0;
  logic [DATA_W-1:0] SAMPLE1;
  logic [1:0]        ADC_OUT;
  logic              BUSY;
  logic              XFER_DONE;

  modport master (
    output ADC_CNVST, ADC_SCLK, ADC_CS_N, SAMPLE0, SAMPLE1,
    input  ADC_OUT, BUSY, XFER_DONE
  );

  modport slave (
    input  ADC_CNVST, ADC_SCLK, ADC_CS_N, SAMPLE0, SAMPLE1,
    output ADC_OUT, BUSY, XFER_DONE
  );
endinterface

// File: rtl/adc_responder.sv
// Emulates a 2-channel serial ADC: latches SAMPLE0/1 on CNVST fall, shifts MSB-first on SCLK falls.
// Pins see ~3 core cycles of sync latency; no backpressure, the external controller paces SCLK.
module adc_responder #(
  parameter int DATA_W  = 12,
  parameter int LATENCY = 3
) (
  input  logic           CLOCK_50MHz,
  input  logic           RESET_n,
  adc_responder_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int LAT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic              cnv_s1_q, cnv_s2_q, cnv_h_q;
  logic              sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic [1:0]        settle_q;
  logic [DATA_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [1:0]        out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic settled, cnv_fall, sclk_rise, sclk_fall;

  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      cnv_s1_q  <= 1'b1;
      cnv_s2_q  <= 1'b1;
      cnv_h_q   <= 1'b1;
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_h_q  <= 1'b0;
      settle_q  <= 2'd0;
    end else begin
      cnv_s1_q  <= bus.ADC_CNVST;
      cnv_s2_q  <= cnv_s1_q;
      cnv_h_q   <= cnv_s2_q;
      sclk_s1_q <= bus.ADC_SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // The CNVST chain restarts at its idle level, so a pin held low through reset would
  // look like a fresh falling edge; edges are ignored until the chain has flushed.
  assign settled   = (settle_q == 2'd3);
  assign cnv_fall  = settled & cnv_h_q & ~cnv_s2_q;
  assign sclk_rise = sclk_s2_q & ~sclk_h_q;
  assign sclk_fall = ~sclk_s2_q & sclk_h_q;

  always_comb begin
    state_d = state_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (bus.ADC_CS_N) begin
      state_d = IDLE;
      out_d   = 2'b00;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          out_d  = 2'b00;
          busy_d = 1'b0;
          if (cnv_fall) begin
            state_d = WAIT;
            sh0_d   = bus.SAMPLE0;
            sh1_d   = bus.SAMPLE1;
            lat_d   = '0;
            bit_d   = '0;
            busy_d  = 1'b1;
          end
        end
        WAIT: begin
          // Abort is checked first so a CNVST release beats any SCLK edge in the same cycle.
          if (cnv_s2_q) begin
            state_d = IDLE;
            out_d   = 2'b00;
            busy_d  = 1'b0;
          end else if (sclk_rise && lat_q != LAT_MAX) begin
            lat_d = lat_q + LAT_W'(1);
          end else if (sclk_fall && lat_q == LAT_MAX) begin
            out_d   = {sh1_q[DATA_W-1], sh0_q[DATA_W-1]};
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (cnv_s2_q) begin
            state_d = IDLE;
            out_d   = 2'b00;
            busy_d  = 1'b0;
          end else if (sclk_rise) begin
            bit_d = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
              state_d = DONE;
              out_d   = 2'b00;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else if (sclk_fall) begin
            sh0_d = sh0_q << 1;
            sh1_d = sh1_q << 1;
            out_d = {sh1_q[DATA_W-2], sh0_q[DATA_W-2]};
          end
        end
        DONE: begin
          out_d  = 2'b00;
          busy_d = 1'b0;
          if (cnv_s2_q) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      sh0_q   <= '0;
      sh1_q   <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      out_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ADC_OUT   = out_q;
  assign bus.BUSY      = busy_q;
  assign bus.XFER_DONE = done_q;
endmodule

// File: tb/tb_adc_responder.sv
// Drives the same pin stimulus into a LATENCY=3 and a LATENCY=0 responder and checks both
// against a bit-position model of the serial word plus hand-computed literal expectations.
module tb_adc_responder;
  localparam int W = 12;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         cnvst = 1'b1;
  logic         sclk  = 1'b0;
  logic         cs_n  = 1'b0;
  logic [W-1:0] s0    = '0;
  logic [W-1:0] s1    = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adc_responder_if #(.DATA_W(W)) bus_a ();
  adc_responder_if #(.DATA_W(W)) bus_b ();

  assign bus_a.ADC_CNVST = cnvst;
  assign bus_a.ADC_SCLK  = sclk;
  assign bus_a.ADC_CS_N  = cs_n;
  assign bus_a.SAMPLE0   = s0;
  assign bus_a.SAMPLE1   = s1;
  assign bus_b.ADC_CNVST = cnvst;
  assign bus_b.ADC_SCLK  = sclk;
  assign bus_b.ADC_CS_N  = cs_n;
  assign bus_b.SAMPLE0   = s0;
  assign bus_b.SAMPLE1   = s1;

  adc_responder #(.DATA_W(W), .LATENCY(3)) dut_a (.CLOCK_50MHz(clk), .RESET_n(rst_n), .bus(bus_a));
  adc_responder #(.DATA_W(W), .LATENCY(0)) dut_b (.CLOCK_50MHz(clk), .RESET_n(rst_n), .bus(bus_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the word appears on the first SCLK fall that follows LATENCY rises after
  // conversion start, each later fall presents the next lower bit, and each rise
  // captures whatever is on the pins; the transfer ends after DATA_W captures.
  int           lat_m[2] = '{3, 0};
  bit           xfer[2];
  int           rises[2], nb[2], caps[2], age[2];
  logic [W-1:0] e0[2], e1[2], cw0[2], cw1[2];
  int           xd_seen[2];
  logic         p_cnv  = 1'b1;
  logic         p_sclk = 1'b0;

  always @(negedge clk) begin
    logic [1:0] o;
    logic       b, x;
    for (int d = 0; d < 2; d++) begin
      o = (d == 0) ? bus_a.ADC_OUT   : bus_b.ADC_OUT;
      b = (d == 0) ? bus_a.BUSY      : bus_b.BUSY;
      x = (d == 0) ? bus_a.XFER_DONE : bus_b.XFER_DONE;
      if (x) xd_seen[d]++;
      if (!rst_n || cs_n) begin
        if (xfer[d]) begin xfer[d] = 1'b0; age[d] = 0; end
      end else if (!xfer[d]) begin
        if (p_cnv && !cnvst) begin
          xfer[d] = 1'b1; age[d] = 0; rises[d] = 0; nb[d] = 0; caps[d] = 0;
          e0[d] = s0; e1[d] = s1; cw0[d] = '0; cw1[d] = '0;
        end
      end else if (cnvst) begin
        xfer[d] = 1'b0; age[d] = 0;
      end else if (sclk && !p_sclk) begin
        if (nb[d] == 0) begin
          check($sformatf("pre_word_out%0d", d), 32'(o), 32'd0);
          rises[d]++;
        end else begin
          check($sformatf("bit_out%0d", d), 32'(o), 32'({e1[d][W-nb[d]], e0[d][W-nb[d]]}));
          cw0[d] = {cw0[d][W-2:0], o[0]};
          cw1[d] = {cw1[d][W-2:0], o[1]};
          caps[d]++;
          if (caps[d] == W) begin xfer[d] = 1'b0; age[d] = 0; end
        end
      end else if (!sclk && p_sclk) begin
        if (nb[d] == 0 && rises[d] >= lat_m[d]) nb[d] = 1;
        else if (nb[d] > 0 && nb[d] < W) nb[d]++;
      end
      if (xfer[d] && age[d] >= 4) check($sformatf("busy_hi%0d", d), 32'(b), 32'd1);
      if (!xfer[d] && age[d] >= 4) begin
        check($sformatf("idle_out%0d", d), 32'(o), 32'd0);
        check($sformatf("idle_busy%0d", d), 32'(b), 32'd0);
      end
      age[d]++;
    end
    p_cnv  = cnvst;
    p_sclk = sclk;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic sclk_periods(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; wait_cyc(4);
      sclk = 1'b1; wait_cyc(4);
    end
  endtask

  task automatic start_conv();
    cnvst = 1'b0;
    wait_cyc(4);
  endtask

  task automatic end_conv();
    sclk = 1'b0;
    wait_cyc(4);
    cnvst = 1'b1;
    wait_cyc(8);
  endtask

  task automatic check_words(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1);
    check({tag, "_a_ch0"}, 32'(cw0[0]), 32'(w0));
    check({tag, "_a_ch1"}, 32'(cw1[0]), 32'(w1));
    check({tag, "_b_ch0"}, 32'(cw0[1]), 32'(w0));
    check({tag, "_b_ch1"}, 32'(cw1[1]), 32'(w1));
  endtask

  task automatic check_done_cnt(input string tag, input int n);
    check({tag, "_xd_a"}, 32'(xd_seen[0]), 32'(n));
    check({tag, "_xd_b"}, 32'(xd_seen[1]), 32'(n));
  endtask

  initial begin
    wait_cyc(3);
    check("rst_out_a",  32'(bus_a.ADC_OUT),   32'd0);
    check("rst_busy_a", 32'(bus_a.BUSY),      32'd0);
    check("rst_xd_a",   32'(bus_a.XFER_DONE), 32'd0);
    check("rst_out_b",  32'(bus_b.ADC_OUT),   32'd0);
    rst_n = 1'b1;
    wait_cyc(6);

    // Basic transfer, SCLK idling low.
    s0 = 12'hA5C; s1 = 12'h3F0;
    start_conv();
    check("start_busy_a", 32'(bus_a.BUSY), 32'd1);
    sclk_periods(3);
    sclk = 1'b0; wait_cyc(4);
    check("msb_a", 32'(bus_a.ADC_OUT), 32'h1);
    sclk = 1'b1; wait_cyc(4);
    sclk_periods(11);
    check("end_busy_a", 32'(bus_a.BUSY), 32'd0);
    check_words("basic", 12'hA5C, 12'h3F0);
    check_done_cnt("basic", 1);
    end_conv();

    // Sample changes mid-word must not disturb the latched word.
    start_conv();
    sclk_periods(5);
    s0 = 12'h001;
    sclk_periods(10);
    check_words("latched", 12'hA5C, 12'h3F0);
    check_done_cnt("latched", 2);
    end_conv();

    // Abort after 5 shifted bits, then a clean restart.
    s0 = 12'h5A3; s1 = 12'hC3C;
    start_conv();
    sclk_periods(8);
    cnvst = 1'b1;
    wait_cyc(4);
    check("abort_out_a",  32'(bus_a.ADC_OUT), 32'd0);
    check("abort_busy_a", 32'(bus_a.BUSY),    32'd0);
    sclk = 1'b0;
    wait_cyc(6);
    check_done_cnt("abort", 2);
    start_conv();
    sclk_periods(15);
    check_words("restart", 12'h5A3, 12'hC3C);
    check_done_cnt("restart", 3);
    end_conv();

    // Chip select deasserted: the conversion request is ignored.
    cs_n = 1'b1;
    wait_cyc(2);
    start_conv();
    sclk_periods(15);
    check("cs_busy_a", 32'(bus_a.BUSY),    32'd0);
    check("cs_out_b",  32'(bus_b.ADC_OUT), 32'd0);
    end_conv();
    cs_n = 1'b0;
    wait_cyc(6);
    check_done_cnt("cs", 3);

    // Reset mid-shift, then no restart until a fresh CNVST fall.
    s0 = 12'hA5C; s1 = 12'h3F0;
    start_conv();
    sclk_periods(6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_a",  32'(bus_a.ADC_OUT), 32'd0);
    check("mid_rst_busy_a", 32'(bus_a.BUSY),    32'd0);
    check("mid_rst_busy_b", 32'(bus_b.BUSY),    32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(6);
    sclk_periods(4);
    check("post_rst_busy_a", 32'(bus_a.BUSY), 32'd0);
    end_conv();
    check_done_cnt("rst", 3);
    start_conv();
    sclk_periods(15);
    check_words("post_rst", 12'hA5C, 12'h3F0);
    check_done_cnt("post_rst", 4);
    end_conv();

    // SCLK idling high: the LATENCY=0 part drives the MSB on the very first fall.
    s0 = 12'hFFF; s1 = 12'h000;
    sclk = 1'b1;
    wait_cyc(6);
    start_conv();
    sclk = 1'b0; wait_cyc(4);
    check("lat0_msb_b", 32'(bus_b.ADC_OUT), 32'h1);
    check("lat0_msb_a", 32'(bus_a.ADC_OUT), 32'h0);
    sclk = 1'b1; wait_cyc(4);
    sclk_periods(14);
    check_words("lat0", 12'hFFF, 12'h000);
    check_done_cnt("lat0", 5);
    end_conv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
